pipelined_subtractor: RTL and testbench
=======================================

# pipelined_subtractor

Multi-stage pipelined integer subtractor: computes operand1_i − operand2_i − borrow_i over BIT_WIDTH bits, one STAGE_WIDTH-bit slice per pipeline stage, with the borrow rippling stage to stage in registers. It complements the combinational adder family in the math/adder area. It is used where a full-width subtract does not close timing in one cycle and a valid/ready stream interface is needed, for example ALU compare/subtract paths and address-bound checks.

## Interface
- BIT_WIDTH, 32, operand/result width; must be a multiple of STAGE_WIDTH.
- STAGE_WIDTH, 8, bits resolved per stage; NUM_STAGES = BIT_WIDTH/STAGE_WIDTH (≥1).
- clk_i  input  1  single clock; all state on rising edge.
- rst_ni  input  1  asynchronous active-low reset.
- valid_i  input  1  input transaction present.
- ready_o  output  1  block accepts the input this cycle.
- operand1_i  input  BIT_WIDTH  minuend.
- operand2_i  input  BIT_WIDTH  subtrahend.
- borrow_i  input  1  borrow-in.
- valid_o  output  1  result present.
- ready_i  input  1  downstream accepts the result.
- diff_o  output  BIT_WIDTH  (operand1_i − operand2_i − borrow_i) mod 2^BIT_WIDTH.
- borrow_o  output  1  1 iff operand1_i < operand2_i + borrow_i (unsigned).
- overflow_o  output  1  two's-complement overflow of the signed subtraction.
- zero_o  output  1  diff_o == 0.

## Operation
- Pipeline of NUM_STAGES register stages, each with a valid bit.
- Input handshake: a transfer occurs when valid_i && ready_o. Output handshake: a transfer occurs when valid_o && ready_i.
- Stage k (0-based) computes slice k as a_k + ~b_k + c_k, where c_0 = ~borrow_i and c_k = the carry-out registered by stage k−1.
- Stage k registers the following:
  - the finished slices 0..k;
  - the carry-out of slice k;
  - the unprocessed upper slices of both operands, carried forward unchanged.
- The last stage's registers drive the outputs directly:
  - diff_o: the assembled slices;
  - borrow_o: ~carry-out of slice NUM_STAGES−1;
  - overflow_o: (a[MSB] != b[MSB]) && (diff[MSB] != a[MSB]), with a[MSB] and b[MSB] carried forward;
  - zero_o: registered alongside the result, not decoded combinationally at the output.
- Backpressure uses a per-stage advance rule. Stage k loads when stage k+1 is empty or stage k+1 is advancing. The last stage advances when ready_i is high or valid_o is low.
- ready_o is high when stage 0 is empty or stage 0 advances this cycle.
- Stalled stages hold data and valid unchanged.
- Bubbles collapse: a later empty stage is filled even while the output is stalled.
- Transactions are never dropped, duplicated or reordered.
- Capacity is NUM_STAGES transactions. With ready_i low and all stages valid, ready_o is 0.
- NUM_STAGES = 1 degenerates to a single registered full-width subtract with the same handshake.

## Timing
- Reset (rst_ni low, asynchronous): all stage valid bits are 0. valid_o=0, diff_o=0, borrow_o=0, overflow_o=0, zero_o=0. ready_o is 1 once reset is released and stays 1 during reset.
- Reset mid-operation discards all in-flight transactions immediately, with no partial outputs.
- Latency: a transaction accepted at edge t appears on valid_o after edge t+NUM_STAGES−1, so it is visible in the cycle following that edge. This is NUM_STAGES cycles of input-to-output latency with no stalls.
- Throughput: one transaction per cycle when ready_i is held high.
- Outputs change only on a clock edge or an asynchronous reset.
- While valid_o=1 and ready_i=0, the outputs are stable.
- Simultaneous accept and drain on a full pipeline: ready_o=1 and the pipeline stays full.
- Wrap-around: results are modulo 2^BIT_WIDTH; borrow_o flags the unsigned underflow.

## Test plan
- Test configuration: BIT_WIDTH=32, STAGE_WIDTH=8 (4 stages), ready_i high unless stated.
- Simple difference: 0x0000_0005 − 0x0000_0003, borrow_i=0 → 4 cycles later diff_o=0x0000_0002, borrow_o=0, overflow_o=0, zero_o=0.
- Unsigned underflow: 0x0000_0000 − 0x0000_0001, borrow_i=0 → diff_o=0xFFFF_FFFF, borrow_o=1, overflow_o=0.
- Borrow chain and zero flag:
  - 0x1234_5678 − 0x1234_5677, borrow_i=1 → diff_o=0, zero_o=1, borrow_o=0;
  - 0x0001_0000 − 0x0000_0001 → 0x0000_FFFF, with the borrow crossing slices 0→1→2.
- Signed overflow: 0x8000_0000 − 0x0000_0001 → diff_o=0x7FFF_FFFF, overflow_o=1, borrow_o=0.
- Backpressure:
  - Stimulus: 10 back-to-back random transactions; ready_i low for 6 cycles starting after the 2nd result.
  - Required: ready_o drops exactly when 4 transactions are held, outputs stay stable while stalled, all 10 results match the reference model in order, and there is no gap once ready_i returns.
- Reset mid-stream: assert rst_ni low asynchronously (mid-cycle) with 3 transactions in flight → valid_o and all outputs go to 0 immediately; after release, no stale result ever appears and a new transaction returns after 4 cycles.

Source files
------------

// File: rtl/pipelined_subtractor.sv
// Pipelined subtractor: one STAGE_WIDTH slice per stage, borrow rippled in registers.
// Operand A rotates out as difference slices rotate in, so the last stage holds the full result.
module pipelined_subtractor #(
  parameter int BIT_WIDTH   = 32,
  parameter int STAGE_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [BIT_WIDTH-1:0] operand1_i,
  input  logic [BIT_WIDTH-1:0] operand2_i,
  input  logic                 borrow_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [BIT_WIDTH-1:0] diff_o,
  output logic                 borrow_o,
  output logic                 overflow_o,
  output logic                 zero_o
);

  localparam int BW = BIT_WIDTH;
  localparam int SW = STAGE_WIDTH;
  localparam int NS = BIT_WIDTH / STAGE_WIDTH;

  logic          vld  [NS];
  logic [BW-1:0] w_q  [NS];
  logic [BW-1:0] b_q  [NS];
  logic          bo_q [NS];
  logic          zf_q [NS];
  logic          ov_q;
  logic [NS:0]   en;

  // en[k]: stage k may load (it is empty or its content moves on)
  always_comb begin
    en     = '0;
    en[NS] = ready_i;
    for (int k = NS - 1; k >= 0; k--) begin
      en[k] = ~vld[k] | en[k+1];
    end
  end

  for (genvar k = 0; k < NS; k++) begin : g_stage
    logic [BW-1:0] w_in;
    logic [BW-1:0] b_in;
    logic          bo_in;
    logic          zf_in;
    logic          v_in;
    logic [SW:0]   sum;
    logic [SW-1:0] d;

    if (k == 0) begin : g_head
      assign w_in  = operand1_i;
      assign b_in  = operand2_i;
      assign bo_in = borrow_i;
      assign zf_in = 1'b1;
      assign v_in  = valid_i;
    end else begin : g_body
      assign w_in  = w_q[k-1];
      assign b_in  = b_q[k-1];
      assign bo_in = bo_q[k-1];
      assign zf_in = zf_q[k-1];
      assign v_in  = vld[k-1];
    end

    assign sum = {1'b0, w_in[SW-1:0]}
               + {1'b0, ~b_in[SW-1:0]}
               + {{SW{1'b0}}, ~bo_in};
    assign d   = sum[SW-1:0];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        vld[k]  <= 1'b0;
        w_q[k]  <= '0;
        b_q[k]  <= '0;
        bo_q[k] <= 1'b0;
        zf_q[k] <= 1'b0;
      end else if (en[k]) begin
        vld[k] <= v_in;
        if (v_in) begin
          w_q[k]  <= (w_in >> SW) | (BW'(d) << (BW - SW));
          b_q[k]  <= b_in >> SW;
          bo_q[k] <= ~sum[SW];
          zf_q[k] <= zf_in & (d == '0);
        end
      end
    end

    // Only the top slice sees both sign bits and the result sign
    if (k == NS - 1) begin : g_ovf
      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          ov_q <= 1'b0;
        end else if (en[k] && v_in) begin
          ov_q <= (w_in[SW-1] != b_in[SW-1])
               && (d[SW-1] != w_in[SW-1]);
        end
      end
    end
  end

  assign ready_o    = en[0];
  assign valid_o    = vld[NS-1];
  assign diff_o     = w_q[NS-1];
  assign borrow_o   = bo_q[NS-1];
  assign zero_o     = zf_q[NS-1];
  assign overflow_o = ov_q;

endmodule

// File: tb/tb_pipelined_subtractor.sv
// Bench for pipelined_subtractor: scoreboard queue of expected results,
// directed vectors, backpressure stall, and asynchronous reset mid-stream.
module tb_pipelined_subtractor;

  localparam int BW = 32;
  localparam int NS = 4;

  typedef struct packed {
    logic [BW-1:0] diff;
    logic          bo;
    logic          ov;
    logic          z;
  } res_t;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          valid_i;
  logic          ready_o;
  logic [BW-1:0] operand1_i;
  logic [BW-1:0] operand2_i;
  logic          borrow_i;
  logic          valid_o;
  logic          ready_i;
  logic [BW-1:0] diff_o;
  logic          borrow_o;
  logic          overflow_o;
  logic          zero_o;

  res_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  pipelined_subtractor #(
    .BIT_WIDTH  (BW),
    .STAGE_WIDTH(8)
  ) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .operand1_i(operand1_i),
    .operand2_i(operand2_i),
    .borrow_i  (borrow_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .diff_o    (diff_o),
    .borrow_o  (borrow_o),
    .overflow_o(overflow_o),
    .zero_o    (zero_o)
  );

  initial forever #5 clk = ~clk;

  function automatic res_t model(logic [BW-1:0] a, logic [BW-1:0] b,
                                 logic bin);
    logic [BW:0] full;
    res_t r;
    full   = {1'b0, a} - {1'b0, b} - {{BW{1'b0}}, bin};
    r.diff = full[BW-1:0];
    r.bo   = full[BW];
    r.ov   = (a[BW-1] != b[BW-1]) && (r.diff[BW-1] != a[BW-1]);
    r.z    = (r.diff == '0);
    return r;
  endfunction

  task automatic test_reset();
    res_t obs;
    rst_ni     = 1'b0;
    valid_i    = 1'b0;
    ready_i    = 1'b1;
    operand1_i = '0;
    operand2_i = '0;
    borrow_i   = 1'b0;
    repeat (2) @(negedge clk);
    obs = {diff_o, borrow_o, overflow_o, zero_o};
    vectors++;
    if (valid_o !== 1'b0 || obs !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: valid_o=%b out=%h want 0", valid_o, obs);
    end
    vectors++;
    if (ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: ready_o=%b want 1", ready_o);
    end
    @(posedge clk);
    #3 rst_ni = 1'b1;
    @(negedge clk);
    vectors++;
    if (ready_o !== 1'b1 || valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL post_reset: ready_o=%b valid_o=%b want 1/0",
               ready_o, valid_o);
    end
  endtask

  task automatic test_directed();
    logic [BW-1:0] ta [7] = '{32'h0000_0005, 32'h0000_0000, 32'h1234_5678,
                              32'h0001_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                              32'h0000_0000};
    logic [BW-1:0] tb [7] = '{32'h0000_0003, 32'h0000_0001, 32'h1234_5677,
                              32'h0000_0001, 32'h0000_0001, 32'hFFFF_FFFF,
                              32'h0000_0000};
    logic          tc [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    res_t          te [7] = '{{32'h0000_0002, 1'b0, 1'b0, 1'b0},
                              {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0},
                              {32'h0000_0000, 1'b0, 1'b0, 1'b1},
                              {32'h0000_FFFF, 1'b0, 1'b0, 1'b0},
                              {32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0},
                              {32'h8000_0000, 1'b1, 1'b1, 1'b0},
                              {32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}};
    res_t obs;
    res_t exp;
    int   lat;
    ready_i = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(posedge clk);
      #1;
      valid_i    = 1'b1;
      operand1_i = ta[i];
      operand2_i = tb[i];
      borrow_i   = tc[i];
      @(negedge clk);
      vectors++;
      if (ready_o !== 1'b1) begin
        miscompares++;
        $display("FAIL dir%0d_ready: ready_o=%b want 1", i, ready_o);
      end
      @(posedge clk);
      sbq.push_back(te[i]);
      #1 valid_i = 1'b0;
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (valid_o !== 1'b1 && lat < 20);
      vectors++;
      if (lat != NS) begin
        miscompares++;
        $display("FAIL dir%0d_latency: got %0d want %0d", i, lat, NS);
      end
      exp = sbq.pop_front();
      obs = {diff_o, borrow_o, overflow_o, zero_o};
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL dir%0d_result: got %h/%b%b%b want %h/%b%b%b", i,
                 obs.diff, obs.bo, obs.ov, obs.z,
                 exp.diff, exp.bo, exp.ov, exp.z);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [BW-1:0] a;
    logic [BW-1:0] b;
    logic          c;
    res_t          obs;
    res_t          exp;
    int            guard;
    int            got;
    int            cyc;
    int            stall;
    bit            resumed;
    got     = 0;
    cyc     = 0;
    stall   = 0;
    resumed = 0;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          a          = $urandom;
          b          = $urandom;
          c          = 1'($urandom_range(1, 0));
          valid_i    = 1'b1;
          operand1_i = a;
          operand2_i = b;
          borrow_i   = c;
          guard      = 0;
          do begin
            @(negedge clk);
            guard++;
          end while (ready_o !== 1'b1 && guard < 100);
          if (ready_o !== 1'b1) begin
            vectors++;
            miscompares++;
            $display("FAIL b2b_accept_timeout: txn %0d not accepted", i);
          end
          @(posedge clk);
          sbq.push_back(model(a, b, c));
          #1;
        end
        valid_i = 1'b0;
      end
      begin
        while (got < 10 && cyc < 400) begin
          @(negedge clk);
          cyc++;
          if (ready_i !== 1'b1) begin
            vectors++;
            if (ready_o !== (sbq.size() < 4)) begin
              miscompares++;
              $display("FAIL stall_ready: ready_o=%b held=%0d",
                       ready_o, sbq.size());
            end
            obs = {diff_o, borrow_o, overflow_o, zero_o};
            vectors++;
            if (sbq.size() == 0 || valid_o !== 1'b1 || obs !== sbq[0]) begin
              miscompares++;
              $display("FAIL stall_hold: valid_o=%b got %h want %h",
                       valid_o, obs, sbq.size() ? sbq[0] : res_t'('0));
            end
            stall--;
            if (stall == 0) begin
              @(posedge clk);
              #1 ready_i = 1'b1;
              resumed = 1;
            end
          end else begin
            if (resumed) begin
              vectors++;
              if (valid_o !== 1'b1) begin
                miscompares++;
                $display("FAIL resume_gap: valid_o=%b want 1 (result %0d)",
                         valid_o, got);
              end
            end
            if (valid_o === 1'b1) begin
              exp = sbq.size() ? sbq.pop_front() : res_t'('x);
              obs = {diff_o, borrow_o, overflow_o, zero_o};
              vectors++;
              if (obs !== exp) begin
                miscompares++;
                $display("FAIL b2b%0d_result: got %h want %h", got, obs, exp);
              end
              got++;
              if (got == 2) begin
                @(posedge clk);
                #1 ready_i = 1'b0;
                stall = 6;
              end
            end
          end
        end
        vectors++;
        if (got != 10) begin
          miscompares++;
          $display("FAIL b2b_count: got %0d results want 10", got);
        end
      end
    join
    ready_i = 1'b1;
  endtask

  task automatic test_reset_midstream();
    res_t obs;
    res_t exp;
    int   lat;
    int   stale;
    ready_i = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      valid_i    = 1'b1;
      operand1_i = BW'(i);
      operand2_i = 32'h0000_0010;
      borrow_i   = 1'b1;
      @(posedge clk);
      sbq.push_back(model(BW'(i), 32'h0000_0010, 1'b1));
      #1;
    end
    valid_i = 1'b0;
    @(posedge clk);
    #4;
    obs = {diff_o, borrow_o, overflow_o, zero_o};
    vectors++;
    if (valid_o !== 1'b1 || obs !== sbq[0]) begin
      miscompares++;
      $display("FAIL pre_reset: valid_o=%b got %h want %h",
               valid_o, obs, sbq[0]);
    end
    rst_ni = 1'b0;
    #1;
    obs = {diff_o, borrow_o, overflow_o, zero_o};
    vectors++;
    if (valid_o !== 1'b0 || obs !== '0) begin
      miscompares++;
      $display("FAIL async_reset: valid_o=%b out=%h want 0", valid_o, obs);
    end
    vectors++;
    if (ready_o !== 1'b1) begin
      miscompares++;
      $display("FAIL async_reset_ready: ready_o=%b want 1", ready_o);
    end
    sbq.delete();
    @(negedge clk);
    #2 rst_ni = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (valid_o !== 1'b0) stale++;
    end
    vectors++;
    if (stale != 0) begin
      miscompares++;
      $display("FAIL stale_after_reset: %0d cycles valid want 0", stale);
    end
    @(posedge clk);
    #1;
    valid_i    = 1'b1;
    operand1_i = 32'h0000_0005;
    operand2_i = 32'h0000_0003;
    borrow_i   = 1'b0;
    @(posedge clk);
    sbq.push_back({32'h0000_0002, 1'b0, 1'b0, 1'b0});
    #1 valid_i = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (valid_o !== 1'b1 && lat < 20);
    vectors++;
    if (lat != NS) begin
      miscompares++;
      $display("FAIL post_reset_latency: got %0d want %0d", lat, NS);
    end
    exp = sbq.pop_front();
    obs = {diff_o, borrow_o, overflow_o, zero_o};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL post_reset_result: got %h want %h", obs, exp);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
